// File: rtl/packet_pkg.sv
// Shared types and default widths for the packet FIFO.
//   DEF_HDR_W / DEF_ADDR_W / DEF_DATA_W : default field widths
//   packet_t : packed header/addr/data bundle at the default widths
package packet_pkg;

  localparam int unsigned DEF_HDR_W  = 16;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_HDR_W-1:0]  header;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } packet_t;

endpackage

// File: rtl/packet_fifo_mem.sv
// Storage array for packet_fifo: DEPTH x WIDTH registers, synchronous write,
// asynchronous (combinational) read. Contents are intentionally not reset.
//   clock    : write clock
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : write bundle
//   i_raddr  : read index
//   o_rdata  : bundle at i_raddr
module packet_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/packet_fifo.sv
// Elastic packet buffer: DEPTH-entry first-word-fall-through FIFO carrying a
// header/addr/data bundle, with an optional header-match drop filter.
//   clock, reset                    : rising-edge clock, async active-high reset
//   inPacket_tx_*                   : producer valid/ready + bundle
//   outPacket_rx_*                  : consumer valid/ready + head bundle
//   filter_en, filter_header        : drop accepted packets whose header matches
//   count                           : occupancy, 0..DEPTH
//   drop_cnt                        : saturating count of filtered packets
module packet_fifo
  import packet_pkg::*;
#(
  parameter int unsigned HDR_W  = DEF_HDR_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inPacket_tx_valid,
  output logic                     inPacket_tx_ready,
  input  logic [HDR_W-1:0]         inPacket_tx_header,
  input  logic [ADDR_W-1:0]        inPacket_tx_addr,
  input  logic [DATA_W-1:0]        inPacket_tx_data,
  output logic                     outPacket_rx_valid,
  input  logic                     outPacket_rx_ready,
  output logic [HDR_W-1:0]         outPacket_rx_header,
  output logic [ADDR_W-1:0]        outPacket_rx_addr,
  output logic [DATA_W-1:0]        outPacket_rx_data,
  input  logic                     filter_en,
  input  logic [HDR_W-1:0]         filter_header,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned W  = HDR_W + ADDR_W + DATA_W;

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_count;
  logic [CNT_W-1:0] r_drop_cnt;

  logic         w_empty;
  logic         w_full;
  logic         w_accept;
  logic         w_match;
  logic         w_push;
  logic         w_drop;
  logic         w_pop;
  logic [W-1:0] w_wdata;
  logic [W-1:0] w_rdata;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Ready depends only on registered state, so a pop never frees a slot for
  // a push in the same cycle.
  assign inPacket_tx_ready  = !w_full;
  assign outPacket_rx_valid = !w_empty;

  assign w_accept = inPacket_tx_valid && inPacket_tx_ready;
  assign w_match  = filter_en && (inPacket_tx_header == filter_header);
  assign w_push   = w_accept && !w_match;
  assign w_drop   = w_accept && w_match;
  assign w_pop    = outPacket_rx_valid && outPacket_rx_ready;

  assign w_wdata = {inPacket_tx_header, inPacket_tx_addr, inPacket_tx_data};

  packet_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign outPacket_rx_header = w_rdata[W-1 -: HDR_W];
  assign outPacket_rx_addr   = w_rdata[DATA_W +: ADDR_W];
  assign outPacket_rx_data   = w_rdata[DATA_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: doc/packet_fifo.md
Name: packet_fifo

Overview:
Parametrised successor to the fixed-width packet passthrough. Carries the packet bundle (header/addr/data) from the tx side to the rx side through a DEPTH-entry FIFO with valid/ready handshake on both sides. Adds an optional header filter that drops matching packets, plus occupancy and saturating drop counters. Sits between packet producers and consumers as an elastic buffer.

Parameters:
HDR_W, 16, header field width
ADDR_W, 16, addr field width
DATA_W, 32, data field width
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, drop counter width

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
inPacket_tx_valid  input  1  producer has a packet
inPacket_tx_ready  output  1  block accepts the packet this cycle
inPacket_tx_header  input  HDR_W  packet header
inPacket_tx_addr  input  ADDR_W  packet address
inPacket_tx_data  input  DATA_W  packet payload
outPacket_rx_valid  output  1  head packet available
outPacket_rx_ready  input  1  consumer takes the head packet
outPacket_rx_header  output  HDR_W  head header
outPacket_rx_addr  output  ADDR_W  head address
outPacket_rx_data  output  DATA_W  head payload
filter_en  input  1  enable header drop filter
filter_header  input  HDR_W  header value to drop
count  output  log2(DEPTH)+1  current occupancy
drop_cnt  output  CNT_W  packets dropped by the filter, saturating

Behaviour:
- Reset: asynchronous on reset high. wr_ptr, rd_ptr, count and drop_cnt go to 0. outPacket_rx_valid=0. inPacket_tx_ready=1 once reset is low. Storage array is not reset. outPacket_rx_* fields are don't-care while valid=0.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. empty when the pointers are fully equal. full when the low bits are equal and the wrap bits differ. Pointers wrap naturally modulo 2*DEPTH.
- inPacket_tx_ready = !full, combinational from registered state only, with no dependence on rx_ready.
- Accept: tx_valid & tx_ready.
  - Accept with the filter matching (filter_en && tx_header==filter_header): discard the packet, leave wr_ptr unchanged, and increment drop_cnt, saturating at 2^CNT_W-1.
  - Accept without a match: write the bundle at wr_ptr[low] and increment wr_ptr.
  - Dropped packets still require tx_ready=1, so a full FIFO back-pressures every packet.
- Output is first-word fall-through:
  - outPacket_rx_valid = !empty.
  - rx fields read combinationally from the array at rd_ptr[low].
  - Pop: rx_valid & rx_ready increments rd_ptr.
- Latency: a packet accepted in cycle N is visible on rx in cycle N+1. There is no combinational tx-to-rx bypass.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - When full, a pop does not enable a same-cycle push, because ready is from registered state. The push is accepted next cycle.
  - When empty, a push and pop cannot coincide because rx_valid=0.
- count = wr_ptr - rd_ptr (modulo arithmetic), range 0..DEPTH, registered.
- filter_en and filter_header are sampled combinationally in the accept cycle. Changing them mid-stream affects only later accepts.
- Handshake rules:
  - The producer must hold its fields stable while valid=1 and ready=0. The block does not check this.
  - The block holds rx fields stable while rx_valid=1 and rx_ready=0.
- Reset asserted mid-operation empties the FIFO immediately. In-flight packets are lost and drop_cnt clears.

Decomposition:
- Shared package packet_pkg holds:
  - the packet struct typedef (header/addr/data) parametrised by the width constants;
  - default constants HDR_W=16, ADDR_W=16, DATA_W=32.
- One natural sub-module, packet_fifo_mem: a DEPTH x (HDR_W+ADDR_W+DATA_W) register array with a synchronous write port and an asynchronous read port.
- Pointer, flag, filter and counter logic stays in packet_fifo.

Test Plan:
- Reset then a single push: hdr=0x1234, addr=0x00A0, data=0xDEADBEEF.
  - Next cycle: rx_valid=1 with the same fields and count=1.
  - Pop: rx_valid=0, count=0.
- Fill, DEPTH=4, rx_ready=0: push 4 packets.
  - count=4, tx_ready=0. A 5th packet is held and not accepted.
  - Pop one: tx_ready=1 on the following cycle.
  - Drain order is 1,2,3,4,5.
- Simultaneous push/pop at count=2 for 10 cycles: count stays 2, output order matches input order, and the pointers wrap at least twice.
- Filter: filter_en=1, filter_header=0x00FF; send headers 0x00FF,0x0001,0x00FF.
  - drop_cnt=2; only 0x0001 appears on rx; count peaks at 1.
- Saturation with CNT_W=2: drop 5 matching packets → drop_cnt=3.
- Async reset with 3 entries queued: assert reset between clock edges.
  - Immediately: rx_valid=0, count=0, drop_cnt=0.
  - After release: tx_ready=1 and a new packet is output alone.
